// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: frame constants, state
// encodings for the loader and its byte receiver, and the length check.
package uart_program_loader_pkg;

  // First byte of every program frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Width of each frame field (SYNC, LEN, data, SUM).
  localparam int FIELD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    GET_LEN,
    GET_DATA,
    GET_SUM,
    RELEASE,
    RUN,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // A frame length is usable when it is non-zero and fits the RAM.
  function automatic logic len_in_range(input logic [FIELD_W-1:0] len,
                                        input int unsigned addr_w);
    return (len != '0) && (32'(len) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 byte receiver for the program loader: synchronises rx, finds the
// start bit, samples each bit mid-cell and flags good or bad stop bits.
// CLKS_PER_BIT must be at least 4 so the half-bit start check is meaningful.
module loader_uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              rx,
  output logic              byte_valid,
  output logic              frame_err,
  output logic [DATA_W-1:0] rx_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  rx_state_t        state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic             fall;
  logic             bit_end;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;

  assign fall = rx_prev & ~rx_sync;

  // Two-flop synchroniser plus edge-detect flop, preset to the idle level.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  // Next state and the end-of-bit-cell strobe where rx_sync is sampled.
  always_comb begin
    state_next = state;
    bit_end    = 1'b0;
    unique case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (cnt == HALF_LAST) begin
                  bit_end    = 1'b1;
                  state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
      RX_DATA:  if (cnt == BIT_LAST) begin
                  bit_end = 1'b1;
                  if (bit_idx == IDX_LAST) state_next = RX_STOP;
                end
      RX_STOP:  if (cnt == BIT_LAST) begin
                  bit_end    = 1'b1;
                  state_next = RX_IDLE;
                end
      default:  state_next = RX_IDLE;
    endcase
  end

  // Baud counter, LSB-first shift register and the one-cycle result pulses.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == RX_IDLE || bit_end) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
      if (state == RX_START && bit_end) bit_idx <= '0;
      if (state == RX_DATA && bit_end) begin
        rx_data <= {rx_sync, rx_data[DATA_W-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == RX_STOP && bit_end) begin
        byte_valid <= rx_sync;
        frame_err  <= ~rx_sync;
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed program image (SYNC, LEN, data, SUM) from UART into the
// CPU RAM while holding the CPU, then clears and releases it on success.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              rx,
  input  logic              prog_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              cpu_clr,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  loader_state_t     state, state_next;
  logic              byte_valid, frame_err;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] sum;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   cnt_next;
  logic              set_err, clr_err, start_frame, write_data;

  loader_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_rx (
    .clk        (clk),
    .clr_n      (clr_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_data    (rx_data)
  );

  assign cnt_next = byte_cnt + CNT_ONE;
  assign cpu_hold = (state != IDLE) && (state != RUN);
  assign cpu_clr  = (state == RELEASE);
  assign done     = (state == RELEASE);

  // Loader state register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_next;
  end

  // Frame parsing: next state plus strobes for the datapath below.
  always_comb begin
    state_next  = state;
    set_err     = 1'b0;
    clr_err     = 1'b0;
    start_frame = 1'b0;
    write_data  = 1'b0;
    unique case (state)
      IDLE: if (prog_en) state_next = WAIT_SYNC;
      WAIT_SYNC, ERROR: begin
        if (!prog_en) begin
          state_next = IDLE;
          set_err    = 1'b1;
        end else if (byte_valid && rx_data == SYNC_BYTE) begin
          state_next = GET_LEN;
          clr_err    = 1'b1;
        end
      end
      GET_LEN: begin
        if (!prog_en) begin
          state_next = IDLE;
          set_err    = 1'b1;
        end else if (frame_err) begin
          state_next = ERROR;
          set_err    = 1'b1;
        end else if (byte_valid) begin
          if (len_in_range(rx_data, ADDR_W)) begin
            state_next  = GET_DATA;
            start_frame = 1'b1;
          end else begin
            state_next = ERROR;
            set_err    = 1'b1;
          end
        end
      end
      GET_DATA: begin
        if (!prog_en) begin
          state_next = IDLE;
          set_err    = 1'b1;
        end else if (frame_err) begin
          state_next = ERROR;
          set_err    = 1'b1;
        end else if (byte_valid) begin
          write_data = 1'b1;
          if (cnt_next == len) state_next = GET_SUM;
        end
      end
      GET_SUM: begin
        if (!prog_en) begin
          state_next = IDLE;
          set_err    = 1'b1;
        end else if (frame_err) begin
          state_next = ERROR;
          set_err    = 1'b1;
        end else if (byte_valid) begin
          if (rx_data == sum) begin
            state_next = RELEASE;
          end else begin
            state_next = ERROR;
            set_err    = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!prog_en) begin
          state_next = IDLE;
          set_err    = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      RUN: if (!prog_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Error flag, frame counters, checksum and the registered RAM write port.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err       <= 1'b0;
      len       <= '0;
      sum       <= '0;
      byte_cnt  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (start_frame) begin
        len      <= rx_data[ADDR_W:0];
        sum      <= '0;
        byte_cnt <= '0;
      end
      if (write_data) begin
        ram_we    <= 1'b1;
        ram_addr  <= byte_cnt[ADDR_W-1:0];
        ram_wdata <= rx_data;
        byte_cnt  <= cnt_next;
        sum       <= sum + rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed frames from the test
// plan followed by randomized frames, checked against a byte-level model.
module tb_uart_program_loader;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int GAP      = 6;

  // Byte-level model phases.
  localparam int M_OFF  = 0;
  localparam int M_HUNT = 1;
  localparam int M_LEN  = 2;
  localparam int M_DATA = 3;
  localparam int M_SUM  = 4;
  localparam int M_RUN  = 5;
  localparam int M_ERR  = 6;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              rx = 1'b1;
  logic              prog_en = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              cpu_hold;
  logic              cpu_clr;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   byte_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int bv_count = 0;

  int         phase = M_OFF;
  logic       m_err = 1'b0;
  int         m_len = 0;
  int         m_cnt = 0;
  logic [7:0] m_sum = 8'h00;
  wr_t        exp_wq[$];
  int         exp_dq[$];
  wr_t        wr_log[$];

  uart_program_loader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .rx        (rx),
    .prog_en   (prog_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .cpu_clr   (cpu_clr),
    .done      (done),
    .err       (err),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  // Advance the model by one received byte; ok is the stop-bit level.
  task automatic model_byte(input logic [7:0] b, input logic ok);
    int bi;
    bi = int'(b);
    if (!prog_en) return;
    case (phase)
      M_HUNT, M_ERR: if (ok && bi == 'hA5) begin
        phase = M_LEN;
        m_err = 1'b0;
      end
      M_LEN: if (!ok || bi == 0 || bi > 16) begin
        phase = M_ERR;
        m_err = 1'b1;
      end else begin
        phase = M_DATA;
        m_len = bi;
        m_cnt = 0;
        m_sum = 8'h00;
      end
      M_DATA: if (!ok) begin
        phase = M_ERR;
        m_err = 1'b1;
      end else begin
        exp_wq.push_back('{m_cnt, bi, cyc});
        m_cnt++;
        m_sum = m_sum + b;
        if (m_cnt == m_len) phase = M_SUM;
      end
      M_SUM: if (ok && b == m_sum) begin
        exp_dq.push_back(cyc);
        phase = M_RUN;
      end else begin
        phase = M_ERR;
        m_err = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Compare process: every write and every release pulse is matched to the model.
  always @(negedge clk) begin
    wr_t e;
    int  lat;
    if (dut.u_rx.byte_valid) bv_count++;
    if (ram_we) begin
      wr_log.push_back('{int'(ram_addr), int'(ram_wdata), cyc});
      checkOutput("we_pending", 32'(exp_wq.size() != 0), 32'd1);
      checkOutput("we_hold", 32'(cpu_hold), 32'd1);
      if (exp_wq.size() != 0) begin
        e = exp_wq.pop_front();
        lat = cyc - e.cyc;
        checkOutput("we_addr", 32'(ram_addr), 32'(e.addr));
        checkOutput("we_data", 32'(ram_wdata), 32'(e.data));
        checkOutput("we_latency", 32'(lat >= 9 && lat <= 14), 32'd1);
      end
    end
    if (cpu_clr || done) begin
      if (cpu_clr) done_count++;
      checkOutput("clr_eq_done", 32'(done), 32'(cpu_clr));
      checkOutput("done_pending", 32'(exp_dq.size() != 0), 32'd1);
      checkOutput("done_hold", 32'(cpu_hold), 32'd1);
      if (exp_dq.size() != 0) begin
        lat = cyc - exp_dq.pop_front();
        checkOutput("done_latency", 32'(lat >= 9 && lat <= 14), 32'd1);
      end
    end
  end

  // Send one 8N1 byte, LSB first; stop_ok=0 sends a low stop bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    model_byte(b, stop_ok);
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) applyStimulus(bytes[i], 1'b1);
  endtask

  task automatic set_prog(input logic v);
    @(negedge clk);
    prog_en = v;
    if (!v) begin
      if (phase != M_OFF && phase != M_RUN) m_err = 1'b1;
      phase = M_OFF;
    end else if (phase == M_OFF) begin
      phase = M_HUNT;
    end
  endtask

  task automatic cycle_prog();
    set_prog(1'b0);
    repeat (2) @(negedge clk);
    set_prog(1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, "_err"}, 32'(err), 32'(m_err));
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'(phase != M_OFF && phase != M_RUN));
    checkOutput({tag, "_cnt"}, 32'(byte_cnt), 32'(m_cnt));
    checkOutput({tag, "_wq_empty"}, 32'(exp_wq.size()), 32'd0);
    checkOutput({tag, "_dq_empty"}, 32'(exp_dq.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_strobes"}, 32'({ram_we, cpu_hold, cpu_clr, done, err}), 32'd0);
    checkOutput({tag, "_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(byte_cnt), 32'd0);
  endtask

  task automatic model_reset();
    phase = M_OFF;
    m_err = 1'b0;
    m_cnt = 0;
    exp_wq.delete();
    exp_dq.delete();
  endtask

  initial begin
    int         d0;
    int         bv0;
    int         nn;
    int         kind;
    int         len;
    int         drop_at;
    int         ferr_at;
    logic [7:0] d;
    logic [7:0] s;
    logic [7:0] frame16[$];

    // Power-on reset.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    clr_n = 1'b1;
    repeat (4) @(negedge clk);

    // Good load.
    $display("[TB] good load");
    set_prog(1'b1);
    repeat (2) @(negedge clk);
    wr_log.delete();
    d0 = done_count;
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    check_state("good");
    checkOutput("good_nwr", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      checkOutput("good_a0", 32'(wr_log[0].addr), 32'h0);
      checkOutput("good_d0", 32'(wr_log[0].data), 32'h11);
      checkOutput("good_a2", 32'(wr_log[2].addr), 32'h2);
      checkOutput("good_d2", 32'(wr_log[2].data), 32'h33);
    end
    checkOutput("good_done", 32'(done_count - d0), 32'd1);
    checkOutput("good_hold_lit", 32'(cpu_hold), 32'd0);
    checkOutput("good_cnt_lit", 32'(byte_cnt), 32'd3);

    // Bad checksum, then recovery from ERROR.
    $display("[TB] bad checksum");
    cycle_prog();
    wr_log.delete();
    d0 = done_count;
    send_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00});
    check_state("badsum");
    checkOutput("badsum_nwr", 32'(wr_log.size()), 32'd2);
    checkOutput("badsum_err_lit", 32'(err), 32'd1);
    checkOutput("badsum_hold_lit", 32'(cpu_hold), 32'd1);
    checkOutput("badsum_nodone", 32'(done_count - d0), 32'd0);
    send_frame('{8'hA5, 8'h01, 8'h07, 8'h07});
    check_state("recover");
    checkOutput("recover_err_lit", 32'(err), 32'd0);
    checkOutput("recover_done", 32'(done_count - d0), 32'd1);

    // Length bounds.
    $display("[TB] length bounds");
    cycle_prog();
    wr_log.delete();
    send_frame('{8'hA5, 8'h00});
    check_state("len0");
    checkOutput("len0_err_lit", 32'(err), 32'd1);
    checkOutput("len0_nwr", 32'(wr_log.size()), 32'd0);
    frame16 = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) frame16.push_back(8'(i * 17 + 3));
    frame16.push_back(8'h28);
    d0 = done_count;
    send_frame(frame16);
    check_state("len16");
    checkOutput("len16_nwr", 32'(wr_log.size()), 32'd16);
    if (wr_log.size() == 16) begin
      checkOutput("len16_last_addr", 32'(wr_log[15].addr), 32'hF);
      checkOutput("len16_last_data", 32'(wr_log[15].data), 32'h02);
    end
    checkOutput("len16_done", 32'(done_count - d0), 32'd1);
    cycle_prog();
    send_frame('{8'hA5, 8'h11});
    check_state("len17");
    checkOutput("len17_err_lit", 32'(err), 32'd1);

    // Framing error during data, then a short glitch on idle rx.
    $display("[TB] framing and glitch");
    cycle_prog();
    send_frame('{8'hA5, 8'h02, 8'h11});
    applyStimulus(8'h22, 1'b0);
    check_state("ferr");
    checkOutput("ferr_err_lit", 32'(err), 32'd1);
    bv0 = bv_count;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch_no_byte", 32'(bv_count - bv0), 32'd0);
    check_state("glitch");

    // Abort by dropping prog_en mid-frame.
    $display("[TB] abort");
    send_frame('{8'hA5, 8'h04, 8'hAA, 8'hBB});
    set_prog(1'b0);
    @(negedge clk);
    checkOutput("abort_hold_lit", 32'(cpu_hold), 32'd0);
    checkOutput("abort_err_lit", 32'(err), 32'd1);
    check_state("abort");

    // Asynchronous reset in the middle of a byte.
    $display("[TB] reset mid-byte");
    set_prog(1'b1);
    repeat (2) @(negedge clk);
    send_frame('{8'hA5, 8'h03, 8'h11});
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CPB + 5) @(negedge clk);
    #2;
    clr_n = 1'b0;
    rx = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    if (prog_en) phase = M_HUNT;
    repeat (2 * CPB) @(negedge clk);
    d0 = done_count;
    send_frame('{8'hA5, 8'h02, 8'h5A, 8'h01, 8'h5B});
    check_state("postrst");
    checkOutput("postrst_done", 32'(done_count - d0), 32'd1);
    checkOutput("postrst_cnt_lit", 32'(byte_cnt), 32'd2);

    // Noise bytes ahead of the sync byte.
    $display("[TB] noise before sync");
    cycle_prog();
    d0 = done_count;
    send_frame('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h46});
    check_state("noise");
    checkOutput("noise_done", 32'(done_count - d0), 32'd1);

    // Randomized frames: noise, bad lengths, bad sums, framing errors, aborts.
    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      cycle_prog();
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        d = 8'($urandom_range(0, 255));
        if (d == 8'hA5) d = 8'h00;
        applyStimulus(d, 1'b1);
      end
      applyStimulus(8'hA5, 1'b1);
      kind = $urandom_range(0, 7);
      if (kind == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
      else           len = $urandom_range(1, 16);
      applyStimulus(8'(len), 1'b1);
      if (len >= 1 && len <= 16) begin
        drop_at = (kind == 1) ? $urandom_range(0, len - 1) : -1;
        ferr_at = (kind == 2) ? $urandom_range(0, len - 1) : -1;
        s = 8'h00;
        for (int i = 0; i < len; i++) begin
          if (i == drop_at) set_prog(1'b0);
          d = 8'($urandom_range(0, 255));
          applyStimulus(d, 1'(i != ferr_at));
          s = s + d;
        end
        if (kind == 3) s = s ^ 8'($urandom_range(1, 255));
        applyStimulus(s, 1'b1);
      end
      check_state("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Serial writer for the CPU's 16x8 RAM: receives a framed program image over UART RX and writes it into RAM addresses 0..N-1.
- Holds the CPU (clock gate/halt) during load.
- On a verified image, pulses a CPU clear and releases the CPU.
- Sits beside the RAM/MAR path in top, muxed ahead of the bus-driven RAM write port.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz
- BAUD, 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 4)
- ADDR_W, 4, RAM address width; max image length = 2**ADDR_W
- DATA_W, 8, RAM word / UART byte width

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- rx  in  1  UART serial input, idle high, 8N1, LSB first
- prog_en  in  1  loader enable (switch/button level)
- ram_we  out  1  one-cycle RAM write strobe
- ram_addr  out  ADDR_W  RAM write address
- ram_wdata  out  DATA_W  RAM write data
- cpu_hold  out  1  high = CPU halted, RAM owned by loader
- cpu_clr  out  1  one-cycle CPU clear pulse after successful load
- done  out  1  one-cycle pulse on successful load
- err  out  1  sticky error flag
- byte_cnt  out  ADDR_W+1  data bytes written in current frame

Behaviour:
- Reset, async on clr_n low: state IDLE; all outputs 0; rx synchroniser flops preset to 1.
- RX front end:
  - 2-flop synchroniser on rx.
  - Start detected on synced 1->0 transition while the receiver is idle; start re-sampled at CLKS_PER_BIT/2; if high, it is a glitch and the receiver returns to idle.
  - Data bits sampled every CLKS_PER_BIT thereafter, LSB first.
  - Stop bit sampled once; 1 gives a byte_valid pulse the next cycle; 0 gives a frame_err pulse and the byte is discarded.
- Frame format: 0xA5 (SYNC), LEN, LEN data bytes, SUM. SUM = 8-bit modulo sum of the data bytes.
- FSM states and transitions:
  - IDLE: cpu_hold=0. If prog_en=1, go to WAIT_SYNC.
  - WAIT_SYNC: cpu_hold=1. byte 0xA5 -> GET_LEN and clear err; other bytes ignored.
  - GET_LEN: LEN in 1..2**ADDR_W -> GET_DATA, with addr=0, sum=0, byte_cnt=0. LEN=0 or LEN>2**ADDR_W -> ERROR.
  - GET_DATA: each byte causes, the cycle after byte_valid, ram_we=1, ram_addr=current index, ram_wdata=byte; then index++, byte_cnt++, sum+=byte. When byte_cnt reaches LEN -> GET_SUM.
  - GET_SUM: byte==sum -> RELEASE; mismatch -> ERROR.
  - RELEASE (1 cycle): cpu_clr=1, done=1, cpu_hold stays 1 -> RUN.
  - RUN: cpu_hold=0. prog_en=0 -> IDLE. While prog_en stays high, no reload occurs until prog_en is cycled.
  - ERROR: err=1 (sticky), cpu_hold=1. byte 0xA5 -> GET_LEN (err cleared). prog_en=0 -> IDLE (err retained until next SYNC).
- Boundary conditions:
  - frame_err in any of GET_LEN/GET_DATA/GET_SUM -> ERROR. In WAIT_SYNC it is ignored.
  - prog_en falling in any state other than IDLE/RUN: abort to IDLE next cycle, err=1. RAM may hold a partial image; the CPU is released only through IDLE.
  - 0xA5 inside GET_LEN/GET_DATA/GET_SUM is treated as ordinary data, not a resync.
  - ram_addr wraps never: LEN is bounded, so the last write goes to 2**ADDR_W-1.
  - ram_we is never asserted outside GET_DATA.
  - cpu_hold deasserts only in IDLE/RUN.
- Latency: stop-bit mid-sample to ram_we = 2 cycles. Last SUM stop-bit sample to cpu_clr = 2 cycles.

Decomposition:
- Shared package/header:
  - SYNC_BYTE = 8'hA5
  - FSM state encodings (IDLE, WAIT_SYNC, GET_LEN, GET_DATA, GET_SUM, RELEASE, RUN, ERROR)
  - frame field widths
- One sub-module: loader_uart_rx.
  - Ports: clk, clr_n, rx, byte_valid, frame_err, byte.
  - Owns the synchroniser, baud counter and shift register.
- Top FSM, sum accumulator and write port live in uart_program_loader.

Test Plan (CLK_FREQ=1600, BAUD=100, so CLKS_PER_BIT=16):
- Good load: prog_en=1, send A5 03 11 22 33 66 -> ram_we pulses with addr 0/1/2 and data 11/22/33; cpu_clr and done pulse once; cpu_hold=0; err=0; byte_cnt=3.
- Bad checksum: send A5 02 01 02 00 -> two writes occur; err=1; cpu_hold stays 1; no cpu_clr. Then send A5 01 07 07 -> err clears, done pulses.
- Length bounds: LEN=00 -> ERROR, no ram_we. LEN=10 (16) with 16 bytes plus correct sum -> last write at addr F, done. LEN=11 -> ERROR.
- Framing/glitch: a 0 stop bit during GET_DATA -> ERROR, err=1. A 4-cycle low glitch on idle rx -> no byte_valid, state unchanged.
- Abort and reset: drop prog_en after the 2nd data byte -> IDLE next cycle, err=1, cpu_hold=0. Pulse clr_n low mid-byte -> all outputs 0 asynchronously, and the next clean frame loads normally.
- Noise before sync: send 00 FF 5A, then a valid frame -> leading bytes ignored in WAIT_SYNC, frame loads correctly.
